// File: rtl/sram_arbiter.sv
// Multi-channel arbiter for a single asynchronous SRAM: picks one requester
// (fixed priority or round-robin) and runs a SETUP/STROBE/FINISH access for it.
module sram_arbiter #(
    parameter int NCH  = 3,
    parameter int AW   = 18,
    parameter int DW   = 16,
    parameter int WAIT = 1,
    parameter int RR   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    wr,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    done,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     sram_addr,
    inout  wire  [DW-1:0]     sram_data,
    output logic              sram_en,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              busy,
    output logic [2:0]        grant
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, FINISH} state_t;

    state_t        state;
    logic [2:0]    rr_ptr;
    logic [2:0]    cnt;
    logic          lat_wr;
    logic          drive;
    logic [DW-1:0] dout;

    logic [2:0]    win;
    logic          any_req;
    logic          hit;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    int            start;
    int            idx;

    assign sram_data = drive ? dout : {DW{1'bz}};

    // Winner: first asserted req scanning upward (with wrap) from the start point.
    always_comb begin
        win       = 3'd0;
        any_req   = 1'b0;
        hit       = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = {AW{1'b0}};
        sel_wdata = {DW{1'b0}};
        start     = (RR != 0) ? int'(rr_ptr) : 0;
        idx       = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (start + k) % NCH;
            for (int i = 0; i < NCH; i++) begin
                hit       = !any_req && (i == idx) && req[i];
                win       = hit ? 3'(i) : win;
                sel_wr    = hit ? wr[i] : sel_wr;
                sel_addr  = hit ? addr[i*AW +: AW] : sel_addr;
                sel_wdata = hit ? wdata[i*DW +: DW] : sel_wdata;
                any_req   = any_req | hit;
            end
        end
    end

    // Access sequencer; all SRAM controls and status outputs are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 3'd0;
            cnt       <= 3'd0;
            lat_wr    <= 1'b0;
            drive     <= 1'b0;
            dout      <= {DW{1'b0}};
            done      <= {NCH{1'b0}};
            rdata     <= {DW{1'b0}};
            grant     <= 3'd0;
            busy      <= 1'b0;
            sram_en   <= 1'b1;
            sram_oe   <= 1'b1;
            sram_we   <= 1'b1;
            sram_addr <= {AW{1'b0}};
        end else begin
            done <= {NCH{1'b0}};
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= SETUP;
                        grant     <= win;
                        lat_wr    <= sel_wr;
                        sram_addr <= sel_addr;
                        dout      <= sel_wdata;
                        drive     <= sel_wr;
                        sram_en   <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= 3'd0;
                        rr_ptr    <= (int'(win) == NCH - 1) ? 3'd0 : win + 3'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    state   <= STROBE;
                    sram_oe <= lat_wr;
                    sram_we <= !lat_wr;
                end
                STROBE: begin
                    if (cnt == 3'(WAIT)) begin
                        state   <= FINISH;
                        sram_oe <= 1'b1;
                        sram_we <= 1'b1;
                        rdata   <= lat_wr ? rdata : sram_data;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    sram_en <= 1'b1;
                    drive   <= 1'b0;
                    for (int i = 0; i < NCH; i++) begin
                        done[i] <= (3'(i) == grant);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    sram_en <= 1'b1;
                    sram_oe <= 1'b1;
                    sram_we <= 1'b1;
                    drive   <= 1'b0;
                end
            endcase
        end
    end
endmodule
